uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares one UART TX line between NUM_REQ byte requesters (e.g. per-core printf
//  channels feeding the UART VIP/console). Round-robin arbiter grants one byte
//  at a time; a built-in serializer emits a start bit, 8 data bits LSB first,
//  an optional even parity bit and one stop bit. Bit timing comes from a
//  runtime clock divider.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DIV_W      16  width of the bit-period divider
//  PARITY_EN  1   1: send parity bit = ^data (receiver XOR of data+parity == 0)
// PORTS
//  clk_i          in   1           single clock
//  rst_i          in   1           synchronous, active-high reset
//  cfg_en_i       in   1           enable new grants
//  cfg_div_i      in   DIV_W       clk cycles per UART bit (0 treated as 1)
//  req_valid_i    in   NUM_REQ     per-requester byte valid
//  req_data_i     in   NUM_REQ*8   byte of requester k at [8k+:8]
//  req_ready_o    out  NUM_REQ     one-hot accept strobe
//  tx_o           out  1           serial line, idle high
//  busy_o         out  1           frame in progress
//  gnt_id_o       out  $clog2(NUM_REQ)  requester owning current/last frame
//  frame_done_o   out  1           1-cycle pulse at end of stop bit
// BEHAVIOUR
//  Reset: tx_o=1, req_ready_o=0, busy_o=0, frame_done_o=0, gnt_id_o=0,
//   rr pointer=0, FSM=IDLE. Reset mid-frame aborts; tx_o=1 after the edge.
//  FSM: IDLE -> START -> DATA(8 bits) -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
//  IDLE: if cfg_en_i and any req_valid_i, winner = first valid index at or
//   after pointer (wrapping). req_ready_o[winner]=1 combinationally that cycle;
//   byte, winner id and cfg_div_i latched; pointer <= (winner+1) mod NUM_REQ;
//   next state START. No valid or cfg_en_i=0: stay IDLE, ready all 0.
//  Ready is only asserted in IDLE; at most one bit ever high.
//  Requesters may drop valid without ready; no data is lost or held.
//  Each bit state lasts exactly max(div,1) cycles, counted by a DIV_W down-
//   counter reloaded per bit; div is the latched value (cfg_div_i changes
//   mid-frame have no effect).
//  tx_o: START=0, DATA=byte[i] i=0..7, PARITY=^byte, STOP=1, IDLE=1.
//   tx_o is registered: first cycle of START is the cycle after accept.
//  busy_o=1 from the cycle after accept through the last STOP cycle.
//  frame_done_o=1 in the last STOP cycle; FSM is IDLE next cycle and can
//   accept again that cycle (back-to-back frames: one idle-high cycle
//   beyond the stop bit).
//  cfg_en_i deasserted mid-frame: current frame completes, no new grant.
//  Frame length: (10 + PARITY_EN) * max(div,1) cycles.
// TESTING
//  1. div=4, PARITY_EN=1, req0 sends 0xA5 -> tx_o: 0,1,0,1,0,0,1,0,1,0(par),1,
//     each 4 cycles; frame_done_o pulses once at cycle 44 after accept.
//  2. All 4 requesters valid continuously -> grant order 0,1,2,3,0,...;
//     exactly one ready pulse per frame.
//  3. Pointer=2, only req1 and req3 valid -> req3 granted, then req1.
//  4. div=0 and div=1 -> identical 1-cycle bits; 0x0A sends parity 0.
//  5. Change cfg_div_i 4->8 mid-frame -> frame stays 4 cycles/bit; next 8.
//  6. rst_i asserted during DATA -> tx_o=1, busy_o=0, ready=0 next cycle;
//     after release req2 valid is granted first (pointer=0, no other valid).

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX line between NUM_REQ byte sources.
// Each granted byte goes out as start, 8 data bits LSB first, optional even parity, and stop.
module uart_tx_sched #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned PARITY_EN = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cfg_en_i,
   input  logic [DIV_W-1:0]             cfg_div_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*8-1:0]         req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic                         tx_o,
   output logic                         busy_o,
   output logic [$clog2(NUM_REQ)-1:0]   gnt_id_o,
   output logic                         frame_done_o
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]       r_state,  w_state;
   logic [DIV_W-1:0] r_cnt,    w_cnt;
   logic [DIV_W-1:0] r_div,    w_div;
   logic [7:0]       r_byte,   w_byte;
   logic [2:0]       r_bit,    w_bit;
   logic [ID_W-1:0]  r_ptr,    w_ptr;
   logic [ID_W-1:0]  r_gnt_id, w_gnt_id;
   logic             r_tx,     w_tx;
   logic             r_busy,   w_busy;
   logic             r_done,   w_done;

   logic             w_found;
   logic [ID_W-1:0]  w_win;
   logic [DIV_W-1:0] w_div_eff;
   logic             w_bit_end;

   assign w_div_eff = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
   assign w_bit_end = (r_cnt == '0);

   // Rotating priority: first valid requester at or after the pointer, wrapping.
   always_comb begin
      logic [ID_W-1:0] v_idx;
      w_found = 1'b0;
      w_win   = '0;
      v_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         v_idx = ID_W'((32'(r_ptr) + i) % NUM_REQ);
         if (!w_found && req_valid_i[v_idx]) begin
            w_found = 1'b1;
            w_win   = v_idx;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_div       = r_div;
      w_byte      = r_byte;
      w_bit       = r_bit;
      w_ptr       = r_ptr;
      w_gnt_id    = r_gnt_id;
      w_tx        = r_tx;
      w_busy      = r_busy;
      req_ready_o = '0;

      if (r_state != S_IDLE && !w_bit_end) begin
         w_cnt = r_cnt - DIV_W'(1);
      end

      case (r_state)
         S_IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            if (cfg_en_i && w_found && !rst_i) begin
               req_ready_o[w_win] = 1'b1;
               w_byte   = req_data_i[{w_win, 3'b000} +: 8];
               w_div    = w_div_eff;
               w_cnt    = w_div_eff - DIV_W'(1);
               w_gnt_id = w_win;
               w_ptr    = ID_W'((32'(w_win) + 32'd1) % NUM_REQ);
               w_state  = S_START;
               w_tx     = 1'b0;
               w_busy   = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_cnt   = r_div - DIV_W'(1);
               w_state = S_DATA;
               w_bit   = 3'd0;
               w_tx    = r_byte[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt = r_div - DIV_W'(1);
               if (r_bit == 3'd7) begin
                  if (PARITY_EN != 0) begin
                     w_state = S_PARITY;
                     w_tx    = ^r_byte;
                  end else begin
                     w_state = S_STOP;
                     w_tx    = 1'b1;
                  end
               end else begin
                  w_bit = r_bit + 3'd1;
                  w_tx  = r_byte[r_bit + 3'd1];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_cnt   = r_div - DIV_W'(1);
               w_state = S_STOP;
               w_tx    = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
               w_tx    = 1'b1;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_tx    = 1'b1;
         end
      endcase

      // Pulse lands on the final cycle of the stop bit.
      w_done = (w_state == S_STOP) && (w_cnt == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_div    <= DIV_W'(1);
         r_byte   <= '0;
         r_bit    <= '0;
         r_ptr    <= '0;
         r_gnt_id <= '0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_div    <= w_div;
         r_byte   <= w_byte;
         r_bit    <= w_bit;
         r_ptr    <= w_ptr;
         r_gnt_id <= w_gnt_id;
         r_tx     <= w_tx;
         r_busy   <= w_busy;
         r_done   <= w_done;
      end
   end

   assign tx_o         = r_tx;
   assign busy_o       = r_busy;
   assign gnt_id_o     = r_gnt_id;
   assign frame_done_o = r_done;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a cycle-level monitor models arbitration and frame bits,
// while a vector table and hand-written sequences drive the requesters.
module tb_uart_tx_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned PEN  = 1;

   logic              clk;
   logic              rst_i;
   logic              cfg_en_i;
   logic [DW-1:0]     cfg_div_i;
   logic [NREQ-1:0]   req_valid_i;
   logic [NREQ*8-1:0] req_data_i;
   logic [NREQ-1:0]   req_ready_o;
   logic              tx_o;
   logic              busy_o;
   logic [1:0]        gnt_id_o;
   logic              frame_done_o;

   uart_tx_sched #(.NUM_REQ(NREQ), .DIV_W(DW), .PARITY_EN(PEN)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .cfg_en_i     (cfg_en_i),
      .cfg_div_i    (cfg_div_i),
      .req_valid_i  (req_valid_i),
      .req_data_i   (req_data_i),
      .req_ready_o  (req_ready_o),
      .tx_o         (tx_o),
      .busy_o       (busy_o),
      .gnt_id_o     (gnt_id_o),
      .frame_done_o (frame_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         id;
      logic [7:0] data;
      int         div;
   } frame_t;

   frame_t sb[$];
   int     gnt_log[$];
   int     accepts = 0;
   int     frames  = 0;
   int     last_acc_id = -1;
   int     m_ptr = 0;

   // Reference model: arbitration, expected bit stream and frame timing.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_i) begin
            m_ptr = 0;
         end else begin
            logic [NREQ-1:0] exp_rdy;
            int              win;
            exp_rdy = '0;
            win     = -1;
            if (cfg_en_i) begin
               for (int i = 0; i < int'(NREQ); i++) begin
                  int k;
                  k = (m_ptr + i) % int'(NREQ);
                  if (win < 0 && req_valid_i[k]) win = k;
               end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("idle_ready", 32'(req_ready_o), 32'(exp_rdy));
            chk("idle_tx", 32'(tx_o), 32'd1);
            chk("idle_busy", 32'(busy_o), 32'd0);
            chk("idle_done", 32'(frame_done_o), 32'd0);
            if (win >= 0) begin
               frame_t e;
               logic   bits [0:10];
               int     nb, n, dv;
               bit     aborted;
               e.id   = win;
               e.data = req_data_i[8*win +: 8];
               e.div  = (cfg_div_i == '0) ? 1 : int'(cfg_div_i);
               sb.push_back(e);
               m_ptr       = (win + 1) % int'(NREQ);
               last_acc_id = win;
               accepts++;
               nb = 10 + int'(PEN);
               bits[0] = 1'b0;
               for (int b = 0; b < 8; b++) bits[b+1] = e.data[b];
               bits[9]    = ^e.data;
               bits[nb-1] = 1'b1;
               dv = e.div;
               n  = nb * dv;
               aborted = 1'b0;
               for (int j = 1; j <= n; j++) begin
                  @(negedge clk);
                  if (rst_i) begin
                     aborted = 1'b1;
                     break;
                  end
                  chk("frame_tx", 32'(tx_o), 32'(bits[(j-1)/dv]));
                  chk("frame_busy", 32'(busy_o), 32'd1);
                  chk("frame_done", 32'(frame_done_o), (j == n) ? 32'd1 : 32'd0);
                  chk("frame_ready", 32'(req_ready_o), 32'd0);
               end
               e = sb.pop_front();
               if (aborted) begin
                  m_ptr = 0;
               end else begin
                  chk("frame_gnt_id", 32'(gnt_id_o), 32'(e.id));
                  gnt_log.push_back(e.id);
                  frames++;
               end
            end
         end
      end
   end

   // Waits for the next accept, then drops the granted requester's valid.
   task automatic wait_accept();
      int start;
      bit ok;
      start = accepts;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk); #1;
         if (accepts > start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: no grant within 60 cycles at %0t", $time);
      end else begin
         @(posedge clk); #1;
         req_valid_i[last_acc_id] = 1'b0;
      end
   endtask

   task automatic wait_frames(input int target);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (frames >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      if (!ok) begin
         errors++;
         $display("FAIL frame_timeout: frames %0d expected %0d", frames, target);
      end
      @(posedge clk); #1;
   endtask

   task automatic set_lanes(input logic [7:0] base, input bit distinct);
      for (int k = 0; k < int'(NREQ); k++)
         req_data_i[8*k +: 8] = distinct ? (base ^ 8'(8'h11 * k)) : base;
   endtask

   typedef struct {
      logic [3:0]  mask;
      logic [7:0]  data;
      logic [15:0] div;
      int          exp_id;
   } vec_t;

   vec_t vecs [0:6];

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n0, a0;
      vecs[0] = '{mask: 4'b0001, data: 8'hA5, div: 16'd4, exp_id: 0};
      vecs[1] = '{mask: 4'b1111, data: 8'h5A, div: 16'd2, exp_id: 1};
      vecs[2] = '{mask: 4'b1010, data: 8'h0A, div: 16'd1, exp_id: 3};
      vecs[3] = '{mask: 4'b1010, data: 8'h0A, div: 16'd0, exp_id: 1};
      vecs[4] = '{mask: 4'b0100, data: 8'hFF, div: 16'd3, exp_id: 2};
      vecs[5] = '{mask: 4'b0011, data: 8'h00, div: 16'd1, exp_id: 0};
      vecs[6] = '{mask: 4'b1001, data: 8'h81, div: 16'd2, exp_id: 3};

      rst_i = 1'b1; cfg_en_i = 1'b1; cfg_div_i = 16'd4;
      req_valid_i = '0; req_data_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk); #1;
      chk("rst_tx", 32'(tx_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(frame_done_o), 32'd0);
      chk("rst_gnt", 32'(gnt_id_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         n0 = frames;
         cfg_div_i = vecs[i].div;
         set_lanes(vecs[i].data, 1'b0);
         req_valid_i = vecs[i].mask;
         wait_accept();
         req_valid_i = '0;
         wait_frames(n0 + 1);
         chk("tbl_gnt", 32'(gnt_log[gnt_log.size()-1]), 32'(vecs[i].exp_id));
      end

      // All requesters valid continuously: strict rotation, one grant per frame.
      cfg_div_i = 16'd1;
      set_lanes(8'h3C, 1'b1);
      n0 = gnt_log.size(); a0 = accepts;
      req_valid_i = 4'hF;
      wait_frames(frames + 6);
      req_valid_i = '0;
      repeat (3) @(posedge clk); #1;
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(gnt_log[n0+k]), 32'(k % 4));
      chk("rr_one_ready_per_frame", 32'(accepts - a0), 32'd6);

      // Pointer sits at 2 with only 1 and 3 valid: 3 wins, then 1.
      n0 = gnt_log.size();
      set_lanes(8'h5A, 1'b1);
      req_valid_i = 4'b1010;
      wait_accept();
      wait_accept();
      wait_frames(frames + 1);
      chk("ptr2_first", 32'(gnt_log[n0]), 32'd3);
      chk("ptr2_second", 32'(gnt_log[n0+1]), 32'd1);

      // Divider change mid-frame only affects the following frame.
      n0 = frames;
      cfg_div_i = 16'd4;
      set_lanes(8'hC3, 1'b1);
      req_valid_i = 4'b0001;
      wait_accept();
      repeat (10) @(posedge clk);
      #1 cfg_div_i = 16'd8;
      wait_frames(n0 + 1);
      req_valid_i = 4'b0001;
      wait_accept();
      wait_frames(n0 + 2);

      // Grants disabled, then disabled again mid-frame.
      a0 = accepts;
      cfg_div_i = 16'd2;
      cfg_en_i = 1'b0;
      req_valid_i = 4'b0100;
      repeat (8) @(posedge clk); #1;
      chk("en_off_no_grant", 32'(accepts), 32'(a0));
      cfg_en_i = 1'b1;
      wait_accept();
      cfg_en_i = 1'b0;
      req_valid_i[0] = 1'b1;
      n0 = frames;
      wait_frames(n0 + 1);
      repeat (20) @(posedge clk); #1;
      chk("en_off_midframe", 32'(accepts), 32'(a0 + 1));
      cfg_en_i = 1'b1;
      wait_accept();
      wait_frames(n0 + 2);

      // Reset during DATA aborts the frame and clears the pointer.
      cfg_div_i = 16'd4;
      set_lanes(8'h96, 1'b1);
      req_valid_i = 4'b0100;
      wait_accept();
      repeat (12) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk); #1;
      chk("abort_tx", 32'(tx_o), 32'd1);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
      n0 = frames;
      req_valid_i = 4'b0100;
      wait_accept();
      chk("post_rst_req2", 32'(last_acc_id), 32'd2);
      wait_frames(n0 + 1);
      req_valid_i = 4'b1010;
      wait_accept();
      chk("post_rst_ptr3", 32'(last_acc_id), 32'd3);
      req_valid_i = '0;
      wait_frames(n0 + 2);

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
